rgmii_tx_if: RTL

RGMII_TX_IF -- requirements
Module: rgmii_tx_if

---
 rtl/rgmii_pkg.sv | 27 ++
 rtl/rgmii_tx_if_oddr.sv | 37 +++
 rtl/rgmii_tx_if.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared speed encodings, byte-period constants and DDR lane layout for the
// RGMII transmit interface.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    localparam int unsigned P_100M = 10;
    localparam int unsigned P_10M  = 100;

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned DDR_W  = 6;

    // One DDR phase worth of pin values, in oddr bit order.
    typedef struct packed {
        logic       txc;
        logic       ctl;
        logic [3:0] txd;
    } ddr_lane_t;

    // Cycles txc stays high within one nibble period of a p-cycle byte period.
    function automatic logic [CNT_W-1:0] txc_high_cycles(input int unsigned p);
        return CNT_W'(((p / 2) + 1) / 2);
    endfunction

endpackage

// File: rtl/rgmii_tx_if_oddr.sv
// Vector DDR output register: d1 is driven while clk is high, d2 while clk is low.
// TARGET/IODDR_STYLE pick between a same-edge launch and a falling-edge retimed launch.
module oddr #(
    parameter string       TARGET      = "GENERIC",
    parameter string       IODDR_STYLE = "IODDR2",
    parameter int unsigned WIDTH       = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] d2_q;

    always_ff @(posedge clk) begin
        d1_q <= d1;
        d2_q <= d2;
    end

    generate
        if ((TARGET == "XILINX" && IODDR_STYLE == "IODDR2") || TARGET == "ALTERA") begin : g_retimed
            // Two-clock style cells launch the low-phase bit from a falling-edge stage.
            logic [WIDTH-1:0] d2_n_q;

            always_ff @(negedge clk) begin
                d2_n_q <= d2_q;
            end

            assign q = clk ? d1_q : d2_n_q;
        end else begin : g_same_edge
            assign q = clk ? d1_q : d2_q;
        end
    endgenerate

endmodule

// File: rtl/rgmii_tx_if.sv
// RGMII transmit adapter: byte-wide MAC side to 4-bit DDR pins at 10/100/1000.
// Optional macro RGMII_TX_ERR_EN: when defined, mac_tx_er is folded into tx_ctl.
module rgmii_tx_if
    import rgmii_pkg::*;
#(
    parameter string TARGET      = "GENERIC",
    parameter string IODDR_STYLE = "IODDR2"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] mac_txd,
    input  logic       mac_tx_en,
    input  logic       mac_tx_er,
    output logic       mac_tx_ce,
    output logic       rgmii_txc,
    output logic [3:0] rgmii_txd,
    output logic       rgmii_tx_ctl
);

    logic [1:0]       speed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       txd_q;
    logic [7:0]       txd_d;
    logic             en_q;
    logic             en_d;
    logic             er_q;
    logic             er_d;

    logic             gig_c;
    logic             speed_chg_c;
    logic             er_in_c;
    logic [CNT_W-1:0] last_c;
    logic [CNT_W-1:0] half_c;
    logic [CNT_W-1:0] high_c;
    logic [CNT_W-1:0] phase_c;
    logic [3:0]       nib_c;
    ddr_lane_t        rise_c;
    ddr_lane_t        fall_c;
    logic [DDR_W-1:0] ddr_q;

`ifdef RGMII_TX_ERR_EN
    assign er_in_c = mac_tx_er;
`else
    logic unused_tx_er;
    assign er_in_c      = 1'b0;
    assign unused_tx_er = mac_tx_er;
`endif

    // Byte-period geometry for the registered speed and the MAC byte strobe.
    always_comb begin
        gig_c  = 1'b1;
        last_c = '0;
        half_c = '0;
        high_c = '0;
        case (speed_q)
            SPEED_10M: begin
                gig_c  = 1'b0;
                last_c = CNT_W'(P_10M - 1);
                half_c = CNT_W'(P_10M / 2);
                high_c = txc_high_cycles(P_10M);
            end
            SPEED_100M: begin
                gig_c  = 1'b0;
                last_c = CNT_W'(P_100M - 1);
                half_c = CNT_W'(P_100M / 2);
                high_c = txc_high_cycles(P_100M);
            end
            SPEED_1G: ;
            default: ;
        endcase
        speed_chg_c = (speed != speed_q);
        mac_tx_ce   = !rst && (gig_c || (cnt_q == last_c));
        phase_c     = (cnt_q < half_c) ? cnt_q : (cnt_q - half_c);
    end

    // Counter and holding-register next state; a speed change overrides capture.
    always_comb begin
        cnt_d = cnt_q;
        txd_d = txd_q;
        en_d  = en_q;
        er_d  = er_q;
        if (speed_chg_c) begin
            cnt_d = '0;
            txd_d = '0;
            en_d  = 1'b0;
            er_d  = 1'b0;
        end else begin
            if (!gig_c) begin
                cnt_d = (cnt_q == last_c) ? '0 : (cnt_q + CNT_W'(1));
            end
            if (mac_tx_ce) begin
                txd_d = mac_txd;
                en_d  = mac_tx_en;
                er_d  = er_in_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        speed_q <= speed;
        if (rst) begin
            cnt_q <= '0;
            txd_q <= '0;
            en_q  <= 1'b0;
            er_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            txd_q <= txd_d;
            en_q  <= en_d;
            er_q  <= er_d;
        end
    end

    // DDR phase values; forced low in reset so the pins idle at zero.
    always_comb begin
        rise_c = '0;
        fall_c = '0;
        nib_c  = (cnt_q < half_c) ? txd_q[3:0] : txd_q[7:4];
        if (!rst) begin
            rise_c.ctl = en_q;
            fall_c.ctl = en_q ^ er_q;
            if (gig_c) begin
                rise_c.txc = 1'b1;
                fall_c.txc = 1'b0;
                rise_c.txd = txd_q[3:0];
                fall_c.txd = txd_q[7:4];
            end else begin
                rise_c.txc = (phase_c < high_c);
                fall_c.txc = (phase_c < high_c);
                rise_c.txd = nib_c;
                fall_c.txd = nib_c;
            end
        end
    end

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (DDR_W)
    ) u_oddr (
        .clk (clk),
        .d1  (rise_c),
        .d2  (fall_c),
        .q   (ddr_q)
    );

    assign {rgmii_txc, rgmii_tx_ctl, rgmii_txd} = ddr_q;

endmodule
